// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

    // Converter control states
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Scratch digits kept internally: enough for any 32-bit value (4294967295)
    localparam int SCRATCH_DIGITS = 10;

    // Saturation nibble shown on every digit when the value does not fit
    localparam logic [3:0] BCD_NINE = 4'h9;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD nibble of 5 or more gets +3 so that
// the following left shift carries correctly into the next decimal digit.
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] din_i,
    output logic [3:0] dout_o
);

    // Add 3 when the digit would become >= 10 after doubling
    always_comb begin
        dout_o = din_i;
        if (din_i >= 4'd5) begin
            dout_o = din_i + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one binary bit consumed per clock.
// The result and overflow flag are registered and only change on the done
// edge (or reset), so downstream 7-segment decoders never see partial values.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WIDTH-1:0]    bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd,
    output logic                ovf
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t                                state_q, state_d;
    logic [CNT_W-1:0]                      cnt_q, cnt_d;
    logic [WIDTH-1:0]                      bin_q, bin_d;
    logic [SCRATCH_DIGITS-1:0][3:0]        dig_q, dig_d;
    logic                                  busy_q, busy_d;
    logic                                  done_q, done_d;
    logic [4*DIGITS-1:0]                   bcd_q, bcd_d;
    logic                                  ovf_q, ovf_d;

    // Scratch digits after the +3 correction and after the one-bit shift
    logic [SCRATCH_DIGITS-1:0][3:0]        dig_adj;
    logic [SCRATCH_DIGITS-1:0][3:0]        dig_shift;
    logic                                  ovf_calc;
    logic [4*DIGITS-1:0]                   bcd_calc;

    // One corrector per scratch digit; the shift chains each digit's MSB into
    // the next digit's LSB, with the binary MSB feeding digit 0.
    generate
        for (genvar gi = 0; gi < SCRATCH_DIGITS; gi++) begin : g_digit
            bcd_digit_adj u_adj (
                .din_i  (dig_q[gi]),
                .dout_o (dig_adj[gi])
            );
            if (gi == 0) begin : g_lsd
                assign dig_shift[gi] = {dig_adj[gi][2:0], bin_q[WIDTH-1]};
            end else begin : g_upper
                assign dig_shift[gi] = {dig_adj[gi][2:0], dig_adj[gi-1][3]};
            end
        end
    endgenerate

    // Overflow if any digit beyond the displayed ones is non-zero after the final shift
    always_comb begin
        ovf_calc = 1'b0;
        for (int k = DIGITS; k < SCRATCH_DIGITS; k++) begin
            ovf_calc = ovf_calc | (dig_shift[k] != 4'd0);
        end
    end

    // Displayed digits, saturated to all nines on overflow
    always_comb begin
        bcd_calc = '0;
        for (int k = 0; k < DIGITS; k++) begin
            bcd_calc[4*k +: 4] = ovf_calc ? BCD_NINE : dig_shift[k];
        end
    end

    // Next-state and datapath control; start is only looked at in IDLE
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        dig_d   = dig_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin;
                    dig_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bin_d = {bin_q[WIDTH-2:0], 1'b0};
                dig_d = dig_shift;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    bcd_d   = bcd_calc;
                    ovf_d   = ovf_calc;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            dig_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            dig_q   <= dig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: a 6-digit and a 10-digit instance share
// the same stimulus; expected digits come from plain decimal arithmetic.
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] bin = '0;

    logic        busy6, done6, ovf6;
    logic [23:0] bcd6;
    logic        busy10, done10, ovf10;
    logic [39:0] bcd10;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bin2bcd_seq #(.WIDTH(32), .DIGITS(6)) u_dut6 (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .busy  (busy6),
        .done  (done6),
        .bcd   (bcd6),
        .ovf   (ovf6)
    );

    bin2bcd_seq #(.WIDTH(32), .DIGITS(10)) u_dut10 (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .busy  (busy10),
        .done  (done10),
        .bcd   (bcd10),
        .ovf   (ovf10)
    );

    // Reference: ten decimal digits by repeated division
    function automatic logic [39:0] ref_dec(input longint unsigned v);
        logic [39:0] r;
        longint unsigned t;
        r = '0;
        t = v;
        for (int k = 0; k < 10; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf6(input longint unsigned v);
        return (v >= 64'd1000000);
    endfunction

    function automatic logic [23:0] ref_bcd6(input longint unsigned v);
        logic [39:0] r;
        r = ref_dec(v);
        return ref_ovf6(v) ? 24'h999999 : r[23:0];
    endfunction

    // Pulse start for one cycle; returns at the falling edge after the accepting edge
    task automatic kick(input logic [31:0] v);
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Wait (bounded) for done; cycles=0 on timeout. Also reports whether the
    // outputs held still before done and how many sampled cycles had busy=1.
    task automatic wait_done(output int cycles, output bit held, output int busy_cnt);
        logic [23:0] p6;
        logic [39:0] p10;
        logic        po;
        p6 = bcd6;
        p10 = bcd10;
        po = ovf6;
        held = 1'b1;
        cycles = 0;
        busy_cnt = busy6 ? 1 : 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (done6) begin
                cycles = i;
                break;
            end
            if (busy6) busy_cnt++;
            if (bcd6 !== p6 || bcd10 !== p10 || ovf6 !== po) held = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (busy6 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy6); end
        n_checks++; if (done6 !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done6); end
        n_checks++; if (bcd6 !== 24'h0) begin n_fail++; $display("FAIL reset_bcd got %h want 000000", bcd6); end
        n_checks++; if (ovf6 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf6); end
        n_checks++; if (bcd10 !== 40'h0) begin n_fail++; $display("FAIL reset_bcd10 got %h want 0", bcd10); end
        reset = 1'b0;
        $display("txn reset released");
    endtask

    task automatic test_zero();
        int c, bc;
        bit h;
        kick(32'd0);
        wait_done(c, h, bc);
        $display("txn zero bin=0 bcd=%h ovf=%b latency=%0d busy=%0d", bcd6, ovf6, c, bc);
        n_checks++; if (c !== 32) begin n_fail++; $display("FAIL zero_latency got %0d want 32", c); end
        n_checks++; if (bc !== 32) begin n_fail++; $display("FAIL zero_busy_cycles got %0d want 32", bc); end
        n_checks++; if (bcd6 !== 24'h000000) begin n_fail++; $display("FAIL zero_bcd got %h want 000000", bcd6); end
        n_checks++; if (ovf6 !== 1'b0) begin n_fail++; $display("FAIL zero_ovf got %b want 0", ovf6); end
        @(negedge clk);
        n_checks++; if (done6 !== 1'b0) begin n_fail++; $display("FAIL zero_done_width got %b want 0", done6); end
    endtask

    task automatic test_known();
        int c, bc;
        bit h;
        kick(32'd123456);
        wait_done(c, h, bc);
        $display("txn known bin=123456 bcd=%h ovf=%b latency=%0d", bcd6, ovf6, c);
        n_checks++; if (c !== 32) begin n_fail++; $display("FAIL known_latency got %0d want 32", c); end
        n_checks++; if (!h) begin n_fail++; $display("FAIL known_hold got changed want stable"); end
        n_checks++; if (bcd6 !== 24'h123456) begin n_fail++; $display("FAIL known_bcd got %h want 123456", bcd6); end
        n_checks++; if (ovf6 !== 1'b0) begin n_fail++; $display("FAIL known_ovf got %b want 0", ovf6); end
    endtask

    task automatic test_back_to_back();
        int c1, c2, bc;
        bit h;
        @(negedge clk);
        start = 1'b1;
        bin   = 32'd999999;
        @(negedge clk);
        wait_done(c1, h, bc);
        $display("txn b2b first bin=999999 bcd=%h ovf=%b latency=%0d", bcd6, ovf6, c1);
        n_checks++; if (c1 !== 32) begin n_fail++; $display("FAIL b2b_first_latency got %0d want 32", c1); end
        n_checks++; if (bcd6 !== 24'h999999) begin n_fail++; $display("FAIL b2b_first_bcd got %h want 999999", bcd6); end
        n_checks++; if (ovf6 !== 1'b0) begin n_fail++; $display("FAIL b2b_first_ovf got %b want 0", ovf6); end
        bin = 32'd1000000;
        wait_done(c2, h, bc);
        start = 1'b0;
        $display("txn b2b second bin=1000000 bcd=%h ovf=%b spacing=%0d", bcd6, ovf6, c2);
        n_checks++; if (c2 !== 33) begin n_fail++; $display("FAIL b2b_spacing got %0d want 33", c2); end
        n_checks++; if (bcd6 !== 24'h999999) begin n_fail++; $display("FAIL b2b_second_bcd got %h want 999999", bcd6); end
        n_checks++; if (ovf6 !== 1'b1) begin n_fail++; $display("FAIL b2b_second_ovf got %b want 1", ovf6); end
        n_checks++; if (bcd10 !== 40'h0001000000) begin n_fail++; $display("FAIL b2b_second_bcd10 got %h want 0001000000", bcd10); end
    endtask

    task automatic test_max();
        int c, bc;
        bit h;
        kick(32'hFFFF_FFFF);
        wait_done(c, h, bc);
        $display("txn max bin=4294967295 bcd6=%h ovf6=%b bcd10=%h ovf10=%b", bcd6, ovf6, bcd10, ovf10);
        n_checks++; if (ovf6 !== 1'b1) begin n_fail++; $display("FAIL max_ovf got %b want 1", ovf6); end
        n_checks++; if (bcd6 !== 24'h999999) begin n_fail++; $display("FAIL max_bcd got %h want 999999", bcd6); end
        n_checks++; if (bcd10 !== 40'h4294967295) begin n_fail++; $display("FAIL max_bcd10 got %h want 4294967295", bcd10); end
        n_checks++; if (ovf10 !== 1'b0) begin n_fail++; $display("FAIL max_ovf10 got %b want 0", ovf10); end
    endtask

    task automatic test_ignore_start();
        int c, bc, extra;
        bit h;
        kick(32'd42);
        for (int i = 0; i < 10; i++) @(negedge clk);
        start = 1'b1;
        bin   = 32'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done(c, h, bc);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done6) extra++;
        end
        $display("txn ignore bin=42 (7 mid-run) bcd=%h latency=%0d extra_done=%0d", bcd6, 11 + c, extra);
        n_checks++; if (11 + c !== 32) begin n_fail++; $display("FAIL ignore_latency got %0d want 32", 11 + c); end
        n_checks++; if (bcd6 !== 24'h000042) begin n_fail++; $display("FAIL ignore_bcd got %h want 000042", bcd6); end
        n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL ignore_extra_done got %0d want 0", extra); end
    endtask

    task automatic test_reset_abort();
        int c, bc, dn;
        bit h;
        kick(32'd555);
        for (int i = 0; i < 9; i++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (busy6 !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy6); end
        n_checks++; if (bcd6 !== 24'h0) begin n_fail++; $display("FAIL abort_bcd got %h want 000000", bcd6); end
        n_checks++; if (ovf6 !== 1'b0) begin n_fail++; $display("FAIL abort_ovf got %b want 0", ovf6); end
        reset = 1'b0;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done6 || busy6) dn++;
        end
        n_checks++; if (dn !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d want 0", dn); end
        kick(32'd555);
        wait_done(c, h, bc);
        $display("txn abort_then_555 bcd=%h latency=%0d", bcd6, c);
        n_checks++; if (c !== 32) begin n_fail++; $display("FAIL abort_restart_latency got %0d want 32", c); end
        n_checks++; if (bcd6 !== 24'h000555) begin n_fail++; $display("FAIL abort_restart_bcd got %h want 000555", bcd6); end
    endtask

    task automatic test_random();
        int c, bc, gap;
        bit h;
        logic [31:0] v;
        for (int t = 0; t < 16; t++) begin
            v = (t % 2 == 0) ? 32'($urandom_range(0, 999999)) : $urandom;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) @(negedge clk);
            kick(v);
            wait_done(c, h, bc);
            $display("txn rand%0d bin=%0d bcd6=%h ovf6=%b bcd10=%h", t, v, bcd6, ovf6, bcd10);
            n_checks++; if (c !== 32) begin n_fail++; $display("FAIL rand_latency got %0d want 32", c); end
            n_checks++; if (!h) begin n_fail++; $display("FAIL rand_hold bin=%0d got changed want stable", v); end
            n_checks++; if (bcd6 !== ref_bcd6(64'(v))) begin n_fail++; $display("FAIL rand_bcd6 bin=%0d got %h want %h", v, bcd6, ref_bcd6(64'(v))); end
            n_checks++; if (ovf6 !== ref_ovf6(64'(v))) begin n_fail++; $display("FAIL rand_ovf6 bin=%0d got %b want %b", v, ovf6, ref_ovf6(64'(v))); end
            n_checks++; if (bcd10 !== ref_dec(64'(v))) begin n_fail++; $display("FAIL rand_bcd10 bin=%0d got %h want %h", v, bcd10, ref_dec(64'(v))); end
            n_checks++; if (ovf10 !== 1'b0) begin n_fail++; $display("FAIL rand_ovf10 bin=%0d got %b want 0", v, ovf10); end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        test_zero();
        test_known();
        test_back_to_back();
        test_max();
        test_ignore_start();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
